// File: rtl/led_pkg.sv
// Shared definitions for the LED burst scheduler and the existing blinker:
// scheduler state encoding, default tick lengths and the index-width helper.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } led_sched_state_t;

  localparam int DEF_ON_TICKS  = 4;
  localparam int DEF_OFF_TICKS = 4;
  localparam int DEF_GAP_TICKS = 12;

  // Width of an index into n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/led_phase_timer.sv
// Loadable down-counter for the scheduler's phase lengths. A load takes
// priority; otherwise the count decrements and then holds at zero.
// While the count is zero, expire is high.
module led_phase_timer #(
  parameter int TIMER_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic [TIMER_W-1:0] count,
  output logic               expire
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;

  // Next count: load, decrement, or hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TIMER_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count  = cnt_q;
  assign expire = (cnt_q == '0);

endmodule

// File: rtl/led_burst_sched.sv
// Shares one status LED among NUM_REQ requesters. A winner is picked in
// IDLE. Its blink code is then played as N on/off pulses, followed by a gap
// and a one-cycle done pulse.
// Optional feature: define LED_BURST_SCHED_RR_EN for round-robin arbitration.
// Without it, arbitration is fixed priority (lowest index wins) and no
// pointer register exists.
module led_burst_sched
  import led_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int CNT_W     = 4,
  parameter int TIMER_W   = 16,
  parameter int ON_TICKS  = DEF_ON_TICKS,
  parameter int OFF_TICKS = DEF_OFF_TICKS,
  parameter int GAP_TICKS = DEF_GAP_TICKS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*CNT_W-1:0]       req_cnt,
  output logic                           led,
  output logic                           busy,
  output logic [idx_w(NUM_REQ)-1:0]      grant_idx,
  output logic [NUM_REQ-1:0]             done
);

  localparam int IDX_W = idx_w(NUM_REQ);
  // Timer loads terminal count minus one so each phase lasts exactly *_TICKS.
  localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_TICKS - 1);
  localparam logic [TIMER_W-1:0] OFF_LOAD = TIMER_W'(OFF_TICKS - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD = TIMER_W'(GAP_TICKS - 1);

  led_sched_state_t   state_q, state_d;
  logic               led_q, led_d;
  logic               busy_q, busy_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [CNT_W-1:0]   rem_q, rem_d;

  logic               win_found_s;
  logic [IDX_W-1:0]   win_idx_s;
  logic [CNT_W-1:0]   win_cnt_s;
  logic               tmr_load_s;
  logic [TIMER_W-1:0] tmr_val_s;
  logic [TIMER_W-1:0] tmr_cnt_s;
  logic [TIMER_W-1:0] tmr_next_s;
  logic               tmr_exp_s;

`ifdef LED_BURST_SCHED_RR_EN
  logic [IDX_W-1:0]   ptr_q, ptr_d;
`endif

  led_phase_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .count    (tmr_cnt_s),
    .expire   (tmr_exp_s)
  );

  // Arbitration: choose the winning requester among the current req bits.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
`ifdef LED_BURST_SCHED_RR_EN
    // Round-robin: the search starts at the pointer and wraps around.
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found_s && req[(int'(ptr_q) + k) % NUM_REQ]) begin
        win_found_s = 1'b1;
        win_idx_s   = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      end else begin
        win_found_s = win_found_s;
      end
    end
`else
    // Fixed priority: scan from high to low so the lowest index wins.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_found_s = 1'b1;
        win_idx_s   = IDX_W'(i);
      end else begin
        win_found_s = win_found_s;
      end
    end
`endif
    win_cnt_s = req_cnt[int'(win_idx_s)*CNT_W +: CNT_W];
  end

  // Next-state logic: phase sequencing, timer loads and output values.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    grant_d    = grant_q;
    tmr_load_s = 1'b0;
    tmr_val_s  = '0;
    done_d     = '0;
`ifdef LED_BURST_SCHED_RR_EN
    ptr_d      = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_found_s) begin
          grant_d    = win_idx_s;
          rem_d      = win_cnt_s;
          tmr_load_s = 1'b1;
`ifdef LED_BURST_SCHED_RR_EN
          if (int'(win_idx_s) == NUM_REQ - 1) begin
            ptr_d = '0;
          end else begin
            ptr_d = win_idx_s + IDX_W'(1);
          end
`endif
          if (win_cnt_s == '0) begin
            state_d   = GAP;
            tmr_val_s = GAP_LOAD;
          end else begin
            state_d   = ON;
            tmr_val_s = ON_LOAD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ON: begin
        if (tmr_exp_s) begin
          rem_d      = rem_q - CNT_W'(1);
          tmr_load_s = 1'b1;
          if (rem_q != CNT_W'(1)) begin
            state_d   = OFF;
            tmr_val_s = OFF_LOAD;
          end else begin
            state_d   = GAP;
            tmr_val_s = GAP_LOAD;
          end
        end else begin
          state_d = ON;
        end
      end
      OFF: begin
        if (tmr_exp_s) begin
          state_d    = ON;
          tmr_load_s = 1'b1;
          tmr_val_s  = ON_LOAD;
        end else begin
          state_d = OFF;
        end
      end
      GAP: begin
        if (tmr_exp_s) begin
          state_d = IDLE;
        end else begin
          state_d = GAP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Timer value in the coming cycle. done is registered, so it is raised
    // one edge early: when the next cycle is GAP with the timer at zero.
    if (tmr_load_s) begin
      tmr_next_s = tmr_val_s;
    end else if (tmr_cnt_s != '0) begin
      tmr_next_s = tmr_cnt_s - TIMER_W'(1);
    end else begin
      tmr_next_s = tmr_cnt_s;
    end
    if ((state_d == GAP) && (tmr_next_s == '0)) begin
      done_d[grant_d] = 1'b1;
    end else begin
      done_d = '0;
    end

    led_d  = (state_d == ON);
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset aborts any code in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      grant_q <= '0;
      done_q  <= '0;
      rem_q   <= '0;
`ifdef LED_BURST_SCHED_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      rem_q   <= rem_d;
`ifdef LED_BURST_SCHED_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign led       = led_q;
  assign busy      = busy_q;
  assign grant_idx = grant_q;
  assign done      = done_q;

endmodule

// File: tb/tb_led_burst_sched.sv
// Directed bench for led_burst_sched. Two instances share the clock and
// reset: dut_a (ON=2, OFF=3, GAP=5) and dut_b (ON=1, OFF=1, GAP=2).
// Inputs are driven and outputs sampled on the falling edge. "Cycle 0" is
// the cycle in which a request is first presented.
module tb_led_burst_sched;

  localparam int NR = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NR-1:0]     req_a, req_b;
  logic [NR*CW-1:0]  cnt_a, cnt_b;
  logic              led_a, led_b, busy_a, busy_b;
  logic [1:0]        gidx_a, gidx_b;
  logic [NR-1:0]     done_a, done_b;

  int n_assert = 0;
  int n_fail   = 0;
  int highs;
  logic [1:0] exp_g [3];

  led_burst_sched #(.NUM_REQ(NR), .CNT_W(CW), .TIMER_W(16),
                    .ON_TICKS(2), .OFF_TICKS(3), .GAP_TICKS(5)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .req_cnt(cnt_a),
    .led(led_a), .busy(busy_a), .grant_idx(gidx_a), .done(done_a));

  led_burst_sched #(.NUM_REQ(NR), .CNT_W(CW), .TIMER_W(16),
                    .ON_TICKS(1), .OFF_TICKS(1), .GAP_TICKS(2)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .req_cnt(cnt_b),
    .led(led_b), .busy(busy_b), .grant_idx(gidx_b), .done(done_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; req_a = '0; req_b = '0; cnt_a = '0; cnt_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_led_a",  32'(led_a),  32'd0);
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_gidx_a", 32'(gidx_a), 32'd0);
    chk("rst_done_a", 32'(done_a), 32'd0);
    chk("rst_led_b",  32'(led_b),  32'd0);
    chk("rst_busy_b", 32'(busy_b), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single requester, count 3; count and req change mid-code are ignored.
    cnt_a[1*CW +: CW] = 4'd3;
    req_a = 4'b0010;
    highs = 0;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      chk("t1_led", 32'(led_a),
          32'((c == 1) || (c == 2) || (c == 6) || (c == 7) || (c == 11) || (c == 12)));
      chk("t1_busy", 32'(busy_a), 32'(c <= 17));
      chk("t1_done", 32'(done_a), (c == 17) ? 32'h2 : 32'h0);
      if (led_a) highs++;
      if (c == 1) chk("t1_gidx", 32'(gidx_a), 32'd1);
      if (c == 4) begin
        cnt_a[1*CW +: CW] = 4'd7;
        req_a = 4'b0000;
      end
    end
    chk("t1_highs", 32'(highs), 32'd6);

    // Count 0 on req[2]: GAP only, done still issued.
    cnt_a = '0;
    req_a = 4'b0100;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk("t2_led",  32'(led_a),  32'd0);
      chk("t2_busy", 32'(busy_a), 32'(c <= 5));
      chk("t2_done", 32'(done_a), (c == 5) ? 32'h4 : 32'h0);
      if (c == 1) chk("t2_gidx", 32'(gidx_a), 32'd2);
      if (c == 6) req_a = 4'b0000;
    end
    @(negedge clk);

    // Contention: req[1] and req[3] held for three codes of 8 cycles each.
`ifdef LED_BURST_SCHED_RR_EN
    exp_g[0] = 2'd3; exp_g[1] = 2'd1; exp_g[2] = 2'd3;
`else
    exp_g[0] = 2'd1; exp_g[1] = 2'd1; exp_g[2] = 2'd1;
`endif
    cnt_a = '0;
    cnt_a[1*CW +: CW] = 4'd1;
    cnt_a[3*CW +: CW] = 4'd1;
    req_a = 4'b1010;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (((c - 1) % 8) == 0) chk("t3_gidx", 32'(gidx_a), 32'(exp_g[(c - 1) / 8]));
      if (((c - 1) % 8) == 6) chk("t3_done", 32'(done_a), 32'(4'b0001 << exp_g[(c - 1) / 8]));
      if (((c - 1) % 8) == 7) chk("t3_idle", 32'(busy_a), 32'd0);
      if (c == 24) req_a = 4'b0000;
    end
    @(negedge clk);

    // Reset during the second ON phase, then a fresh request.
    cnt_a = '0;
    cnt_a[2*CW +: CW] = 4'd2;
    req_a = 4'b0100;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) chk("t4_gidx", 32'(gidx_a), 32'd2);
    end
    chk("t4_on2", 32'(led_a), 32'd1);
    rst = 1'b1;
    req_a = 4'b0000;
    @(negedge clk);
    chk("t4_rst_led",  32'(led_a),  32'd0);
    chk("t4_rst_busy", 32'(busy_a), 32'd0);
    chk("t4_rst_done", 32'(done_a), 32'd0);
    chk("t4_rst_gidx", 32'(gidx_a), 32'd0);
    rst = 1'b0;
    cnt_a = '0;
    cnt_a[3*CW +: CW] = 4'd1;
    req_a = 4'b1000;
    @(negedge clk);
    chk("t4_new_led",  32'(led_a),  32'd1);
    chk("t4_new_busy", 32'(busy_a), 32'd1);
    chk("t4_new_gidx", 32'(gidx_a), 32'd3);
    for (int c = 2; c <= 7; c++) begin
      @(negedge clk);
      chk("t4_new_done", 32'(done_a), (c == 7) ? 32'h8 : 32'h0);
    end
    req_a = 4'b0000;

    // Count 15 with ON=OFF=1 on dut_b: 15 high cycles, GAP, then done.
    cnt_b[0 +: CW] = 4'd15;
    req_b = 4'b0001;
    highs = 0;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      chk("t5_led",  32'(led_b),  32'((c <= 29) && ((c % 2) == 1)));
      chk("t5_busy", 32'(busy_b), 32'(c <= 31));
      chk("t5_done", 32'(done_b), (c == 31) ? 32'h1 : 32'h0);
      if (led_b) highs++;
      if (c == 1) chk("t5_gidx", 32'(gidx_b), 32'd0);
      if (c == 32) req_b = 4'b0000;
    end
    chk("t5_highs", 32'(highs), 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/led_burst_sched.md
# led_burst_sched

Scheduler that shares one status LED among `NUM_REQ` requesters, each asking to flash a blink code of N pulses. It arbitrates pending requests, then plays the winner's code as N on/off pulses with fixed tick lengths. A fixed inter-code gap follows each code, and the block returns a one-cycle done pulse to the requester. It sits between the subsystem status sources and the board LED pin, and replaces per-source free-running blinkers.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `CNT_W`, default 4: width of each requested pulse count.
- `TIMER_W`, default 16: width of the phase timer.
- `ON_TICKS`, default 4: clk cycles the LED is high per pulse. Range 1..2^TIMER_W-1.
- `OFF_TICKS`, default 4: clk cycles the LED is low between pulses. Same range.
- `GAP_TICKS`, default 12: clk cycles the LED is low after the last pulse. Same range.
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NUM_REQ  level request per requester.
- `req_cnt`  in  NUM_REQ*CNT_W  pulse count; requester i uses bits [i*CNT_W +: CNT_W].
- `led`  out  1  LED drive.
- `busy`  out  1  high in any state other than IDLE.
- `grant_idx`  out  $clog2(NUM_REQ)  index of the requester being served; holds its last value in IDLE.
- `done`  out  NUM_REQ  one-hot, one-cycle completion pulse.

## Operation
- States: IDLE, ON, OFF, GAP.
- Reset values: state IDLE, `led`=0, `busy`=0, `grant_idx`=0, `done`=0, timer=0, remaining count=0, RR pointer=0.
- IDLE, no `req` bit set: remain in IDLE.
- IDLE, any `req` bit set:
  - Select the winner per the arbitration rule.
  - Latch `grant_idx`.
  - Latch the winner's `req_cnt` into the remaining-count register.
  - Next state is ON, or GAP if the latched count is 0.
- ON: `led`=1. After ON_TICKS cycles, decrement the remaining count. Go to OFF if the count is still nonzero, else go to GAP.
- OFF: `led`=0. After OFF_TICKS cycles, go to ON.
- GAP: `led`=0. In the last GAP cycle, assert `done[grant_idx]`. Next state is IDLE.
- `led` is a registered output: it equals 1 exactly in ON-state cycles.
- Requesters are sampled only in IDLE. A `req` change during a code has no effect on that code.
- `req_cnt` is sampled only at grant. Later changes are ignored.
- A requester must drop `req` in the cycle after `done`. If `req` is still high in IDLE, that requester competes again and is re-granted per the arbitration rule.
- Arbitration without the macro: fixed priority, lowest index wins.
- Count 0: no pulses. The block still spends one GAP phase and still issues `done`.
- Count 2^CNT_W-1: plays the full count. No wrap.
- Timer loads terminal count minus 1 on entry to each phase and counts down to 0. The compare is exact at every width.
- Reset mid-code: the code is aborted, no `done` is issued, and all outputs take their reset values on the next edge.

## Timing
- Request seen in IDLE at cycle t: first ON cycle is t+1, and `busy` rises at t+1.
- Code of N≥1 pulses: N·ON_TICKS + (N-1)·OFF_TICKS + GAP_TICKS cycles, starting at t+1.
- `done` is asserted in the final GAP cycle. The next cycle is IDLE with `busy`=0.
- IDLE always lasts at least 1 cycle between codes.
- Back-to-back request: the earliest next grant is 2 cycles after `done`.

## Configuration
- `LED_BURST_SCHED_RR_EN` defined: round-robin arbitration.
  - The search starts at index ptr.
  - On each grant, ptr becomes `grant_idx`+1, modulo NUM_REQ.
  - Any continuously requesting source is served within NUM_REQ codes.
- `LED_BURST_SCHED_RR_EN` undefined: fixed priority, and no pointer register exists.

## Structure
- Shared package `led_pkg` holds:
  - state enum `led_sched_state_t` (IDLE, ON, OFF, GAP);
  - default tick constants;
  - a `clog2`-based index-width helper, shared with the existing blinker.
- Sub-module `led_phase_timer`: a loadable down-counter with `load`, `load_val`, and an `expire` flag. It is TIMER_W wide and uses the same `clk`/`rst`. The FSM instantiates it once.

## Test plan
- Single requester. ON=2, OFF=3, GAP=5; `req[1]`=1 with count 3, seen at cycle 0. Required response:
  - `led` high in cycles 1-2, 6-7, 11-12;
  - `grant_idx`=1;
  - `done`=4'b0010 in cycle 17 only;
  - `busy`=0 in cycle 18.
- Count 0 on `req[2]`: `led` stays 0, `busy` is high for exactly GAP_TICKS cycles, and `done[2]` pulses once.
- Contention. `req`=4'b1010 held continuously, fixed priority: index 1 is served every code. With `LED_BURST_SCHED_RR_EN`: grants alternate 1, 3, 1, 3.
- `req_cnt` changed from 3 to 7 mid-code: exactly 3 pulses are produced. A `req` drop mid-code has no effect.
- `rst` asserted during the second ON phase: the next cycle has `led`=0, `busy`=0, `done`=0. A fresh request after reset gives a first ON cycle one cycle after it is seen.
- Count 15 with CNT_W=4 and ON=OFF=1: exactly 15 high cycles, then the GAP phase and `done`.
